// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
// Imported by the picker and the top level.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int ID_W      = $clog2(N_REQ_DEF);

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotating-priority search over eligible requesters starting at ptr.
// Purely combinational; first eligible index at or after ptr wins.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   w,
    output logic [N_REQ-1:0] w_oh
);

    logic [N_REQ-1:0] elig;

    assign elig = req & ~mask;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        w     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                w     = IDW'(idx);
            end
        end
        w_oh = found ? (N_REQ'(1) << w) : '0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning the single shared q/q_bar register.
// One write per edge; the last winner is masked for one edge.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic [15:0]                wr_count
);

    localparam int IDW = $clog2(N_REQ);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] mask;
    logic             found;
    logic [IDW-1:0]   win;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]   gnt_id_nxt;

    // Only a live grant masks its owner; IDLE never holds a stale gnt.
    assign mask = (state == GRANT) ? gnt : '0;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (req),
        .mask  (mask),
        .ptr   (ptr),
        .found (found),
        .w     (win),
        .w_oh  (win_oh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = found ? GRANT : IDLE;
            GRANT: state_nxt = found ? GRANT : IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        if (found) begin
            gnt_nxt    = win_oh;
            gnt_id_nxt = win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            q_bar    <= '1;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            wr_count <= '0;
        end else begin
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            if (found) begin
                q        <= wdata[int'(win)*WIDTH +: WIDTH];
                q_bar    <= ~wdata[int'(win)*WIDTH +: WIDTH];
                ptr      <= (int'(win) == N_REQ - 1) ? '0 : win + IDW'(1);
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with hand-computed expectations.
// Covers reset, single/multi requester rotation, idle, wrap and reset.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [7:0]  q;
    logic [7:0]  q_bar;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    reg_write_arbiter #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .q        (q),
        .q_bar    (q_bar),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        #2;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qbar", 32'(q_bar), 32'hFF);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_wr", 32'(wr_count), 32'h0);
        #10 rst = 1'b0;

        // write A5 then assert reset mid-cycle
        req   = 4'b0001;
        wdata = 32'h000000A5;
        edge1();
        chk("a5_q", 32'(q), 32'hA5);
        chk("a5_qbar", 32'(q_bar), 32'h5A);
        chk("a5_gnt", 32'(gnt), 32'h1);
        chk("a5_wr", 32'(wr_count), 32'h1);
        req = '0;
        #3 rst = 1'b1;
        #1;
        chk("async_q", 32'(q), 32'h00);
        chk("async_qbar", 32'(q_bar), 32'hFF);
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_wr", 32'(wr_count), 32'h0);
        #1 rst = 1'b0;

        // single persistent requester: grant every other edge
        req   = 4'b0100;
        wdata = 32'h003C0000;
        edge1();
        chk("single_e1_gnt", 32'(gnt), 32'h4);
        chk("single_e1_q", 32'(q), 32'h3C);
        edge1();
        chk("single_e2_gnt", 32'(gnt), 32'h0);
        edge1();
        chk("single_e3_gnt", 32'(gnt), 32'h4);
        edge1();
        chk("single_e4_gnt", 32'(gnt), 32'h0);
        chk("single_q", 32'(q), 32'h3C);
        chk("single_qbar", 32'(q_bar), 32'hC3);
        chk("single_wr", 32'(wr_count), 32'h2);

        // pointer back to 0
        req = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // all requesters held: order 0,1,2,3
        req   = 4'b1111;
        wdata = 32'h13121110;
        edge1();
        chk("all_e1_gnt", 32'(gnt), 32'h1);
        chk("all_e1_q", 32'(q), 32'h10);
        edge1();
        chk("all_e2_gnt", 32'(gnt), 32'h2);
        chk("all_e2_id", 32'(gnt_id), 32'h1);
        edge1();
        chk("all_e3_gnt", 32'(gnt), 32'h4);
        chk("all_e3_id", 32'(gnt_id), 32'h2);
        edge1();
        chk("all_e4_gnt", 32'(gnt), 32'h8);
        chk("all_e4_id", 32'(gnt_id), 32'h3);
        chk("all_q", 32'(q), 32'h13);
        chk("all_wr", 32'(wr_count), 32'h4);

        // rotation: grant 1 (ptr->2), idle, then 0011 wraps to 0
        req = '0;
        edge1();
        chk("rot_idle_gnt", 32'(gnt), 32'h0);
        req = 4'b0010;
        edge1();
        chk("rot_g1_gnt", 32'(gnt), 32'h2);
        req = '0;
        edge1();
        req = 4'b0011;
        edge1();
        chk("rot_wrap_gnt", 32'(gnt), 32'h1);
        chk("rot_wrap_id", 32'(gnt_id), 32'h0);
        chk("rot_wrap_q", 32'(q), 32'h10);
        edge1();
        chk("rot_next_gnt", 32'(gnt), 32'h2);
        chk("rot_next_q", 32'(q), 32'h11);
        chk("rot_wr", 32'(wr_count), 32'h7);

        // idle for 3 edges
        req = '0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("idle_gnt", 32'(gnt), 32'h0);
        end
        chk("idle_state", 32'(dut.state), 32'(IDLE));
        chk("idle_q", 32'(q), 32'h11);
        chk("idle_wr", 32'(wr_count), 32'h7);

        // run count up to FFFF with alternating writes (ptr=2 -> 0 first)
        req = 4'b0011;
        for (int n = 7; n < 32'hFFFF; n++) edge1();
        chk("pre_wrap_wr", 32'(wr_count), 32'hFFFF);
        chk("pre_wrap_gnt", 32'(gnt), 32'h2);
        edge1();
        chk("wrap_wr", 32'(wr_count), 32'h0000);
        chk("wrap_gnt", 32'(gnt), 32'h1);
        edge1();
        chk("post_wrap_gnt", 32'(gnt), 32'h2);

        // reset while gnt=0010; ptr would have been 2
        req   = 4'b1010;
        wdata = 32'hB3005B00;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_q", 32'(q), 32'h00);
        #1 rst = 1'b0;
        edge1();
        chk("rel_gnt", 32'(gnt), 32'h2);
        chk("rel_q", 32'(q), 32'h5B);
        chk("rel_wr", 32'(wr_count), 32'h1);
        edge1();
        chk("rel2_gnt", 32'(gnt), 32'h8);
        chk("rel2_q", 32'(q), 32'hB3);
        chk("rel2_qbar", 32'(q_bar), 32'h4C);
        chk("rel2_wr", 32'(wr_count), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
